// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path:
// opcodes, instruction field positions, sequencer states and helpers.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 12;
    localparam int TYPE_BIT = 11;
    localparam int RD_HI    = 10;
    localparam int RD_LO    = 8;
    localparam int RS_HI    = 7;
    localparam int RS_LO    = 5;
    localparam int RM_HI    = 4;
    localparam int RM_LO    = 2;
    localparam int IMM_HI   = 4;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDI);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_ADD) ||
               (op == OP_ADDI) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Splits an instruction word into its fields and the sign-extended
// 5-bit immediate. Purely combinational.
module instr_fields
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [3:0]  opcode_o,
    output logic        type_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rs_o,
    output logic [2:0]  rm_o,
    output logic [15:0] n_o
);

    assign opcode_o = ir_i[OP_HI:OP_LO];
    assign type_o   = ir_i[TYPE_BIT];
    assign rd_o     = ir_i[RD_HI:RD_LO];
    assign rs_o     = ir_i[RS_HI:RS_LO];
    assign rm_o     = ir_i[RM_HI:RM_LO];
    assign n_o      = {{11{ir_i[IMM_HI]}}, ir_i[IMM_HI:0]};

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer.
// One instruction in flight; fetch uses a req/ack handshake.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] N,
    output logic [2:0]        rs_addr,
    output logic [2:0]        rm_addr,
    input  logic [DATA_W-1:0] aluout,
    output logic              wb_en,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    output logic              halted,
    output logic [DATA_W-1:0] instr_count
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;

    logic [3:0]        opcode;
    logic              unused_type;

    instr_fields u_fields (
        .ir_i     (ir_q),
        .opcode_o (opcode),
        .type_o   (unused_type),
        .rd_o     (wb_addr),
        .rs_o     (rs_addr),
        .rm_o     (rm_addr),
        .n_o      (N)
    );

    // A request, once raised, is held by pend_q until acked even if run drops.
    assign mem_req     = rst_n & (state_q == FETCH) & (run | pend_q);
    assign wb_en       = rst_n & (state_q == WB) & writes_rd(opcode);
    assign illegal     = rst_n & (state_q == WB) & ~is_legal(opcode);
    assign halted      = rst_n & (state_q == HALT);
    assign mem_addr    = pc_q;
    assign instruction = ir_q;
    assign wb_data     = res_q;
    assign instr_count = cnt_q;

    // Next-state logic: advance one phase per cycle, FETCH waits for ack.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        unique case (state_q)
            FETCH: begin
                pend_d = mem_req & ~mem_ack;
                if (mem_req && mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                res_d   = aluout;
                state_d = WB;
            end
            WB: begin
                pc_d    = pc_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (opcode == OP_HALT) ? HALT : FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: stimulus pushes expected
// writeback/illegal events; a monitor pops and compares them.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run, mem_ack;
    logic [15:0] mem_rdata, aluout;
    logic        mem_req, wb_en, illegal, halted;
    logic [15:0] mem_addr, instruction, N, wb_data, instr_count;
    logic [2:0]  rs_addr, rm_addr, wb_addr;

    logic        w_rst_n, w_run, w_ack;
    logic [15:0] w_rdata, w_alu;
    logic        w_req, w_wb_en, w_ill, w_halted;
    logic [15:0] w_addr, w_instr, w_n, w_wb_data, w_cnt;
    logic [2:0]  w_rs, w_rm, w_wb_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic        ill;
        logic [2:0]  rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] instr;
        int          waits;
        logic [15:0] alu;
        logic [15:0] pc;
        logic [2:0]  rd, rs, rm;
        logic [15:0] n;
        int          kind;
        logic [15:0] cnt;
        logic        abort;
    } vec_t;
    vec_t vecs[7];

    control_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instruction(instruction), .N(N),
        .rs_addr(rs_addr), .rm_addr(rm_addr),
        .aluout(aluout), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .halted(halted),
        .instr_count(instr_count)
    );

    control_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .run(w_run),
        .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_ack), .mem_rdata(w_rdata),
        .instruction(w_instr), .N(w_n),
        .rs_addr(w_rs), .rm_addr(w_rm),
        .aluout(w_alu), .wb_en(w_wb_en),
        .wb_addr(w_wb_addr), .wb_data(w_wb_data),
        .illegal(w_ill), .halted(w_halted),
        .instr_count(w_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: every wb_en or illegal pulse must match the next expectation.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #2;
            if (wb_en || illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {illegal, wb_en}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_kind", {illegal, wb_en}, {e.ill, ~e.ill});
                    chk("wb_cycle", cyc, e.cyc);
                    if (!e.ill) begin
                        chk("wb_addr", wb_addr, e.rd);
                        chk("wb_data", wb_data, e.data);
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   t0;
        exp_t e;
        run = 1'b1;
        #1;
        t0 = cyc;
        chk("req_raise", mem_req, 1'b1);
        chk("fetch_addr", mem_addr, v.pc);
        for (int w = 0; w < v.waits; w++) begin
            mem_ack = 1'b0;
            @(negedge clk);
            run = 1'b0;
            #1;
            chk("req_held", mem_req, 1'b1);
            chk("addr_held", mem_addr, v.pc);
        end
        mem_ack   = 1'b1;
        mem_rdata = v.instr;
        if (v.kind != 0) begin
            e.ill  = (v.kind == 2);
            e.rd   = v.rd;
            e.data = v.alu;
            e.cyc  = t0 + v.waits + 3;
            sb.push_back(e);
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        run       = 1'b0;
        aluout    = v.alu;
        #1;
        chk("ir", instruction, v.instr);
        chk("imm_n", N, v.n);
        chk("rs_addr", rs_addr, v.rs);
        chk("rm_addr", rm_addr, v.rm);
        chk("rd_field", wb_addr, v.rd);
        @(negedge clk);
        if (v.abort) begin
            rst_n = 1'b0;
            @(negedge clk);
            #1;
            chk("abort_no_wb", wb_en, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("abort_pc", mem_addr, 16'h0000);
            chk("abort_cnt", instr_count, v.cnt);
            return;
        end
        @(negedge clk);
        #1;
        chk("ir_hold_wb", instruction, v.instr);
        @(negedge clk);
        #1;
        chk("instr_count", instr_count, v.cnt);
    endtask

    initial begin
        vecs[0] = '{16'h8A48, 0, 16'h0010, 16'h0000, 3'd2, 3'd2, 3'd2,
                    16'h0008, 1, 16'd1, 1'b0};
        vecs[1] = '{16'h991F, 0, 16'h1234, 16'h0001, 3'd1, 3'd0, 3'd7,
                    16'hFFFF, 1, 16'd2, 1'b0};
        vecs[2] = '{16'h8C84, 3, 16'h00AB, 16'h0002, 3'd4, 3'd4, 3'd1,
                    16'h0004, 1, 16'd3, 1'b0};
        vecs[3] = '{16'h8000, 0, 16'h5555, 16'h0003, 3'd0, 3'd0, 3'd0,
                    16'h0000, 1, 16'd4, 1'b0};
        vecs[4] = '{16'h8A48, 1, 16'h0BAD, 16'h0004, 3'd2, 3'd2, 3'd2,
                    16'h0008, 0, 16'd0, 1'b1};
        vecs[5] = '{16'h5000, 0, 16'h7777, 16'h0000, 3'd0, 3'd0, 3'd0,
                    16'h0000, 2, 16'd1, 1'b0};
        vecs[6] = '{16'hF000, 0, 16'h0000, 16'h0001, 3'd0, 3'd0, 3'd0,
                    16'h0000, 0, 16'd2, 1'b0};

        rst_n = 1'b0; run = 1'b1; mem_ack = 1'b0;
        mem_rdata = 16'h0000; aluout = 16'h0000;
        w_rst_n = 1'b0; w_run = 1'b0; w_ack = 1'b0;
        w_rdata = 16'h0000; w_alu = 16'h0000;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_flags", {wb_en, illegal, halted}, 3'b000);
        chk("rst_cnt", instr_count, 16'h0000);
        chk("rst_pc", mem_addr, 16'h0000);
        chk("rst_ir", instruction, 16'h0000);

        @(negedge clk);
        rst_n     = 1'b1;
        run       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'h5000;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("ack_no_req", instruction, 16'h0000);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            run = 1'b1;
            @(negedge clk);
            #1;
            chk("halt_state", {halted, mem_req}, 2'b10);
        end

        @(negedge clk);
        w_rst_n = 1'b1;
        w_run   = 1'b1;
        #1;
        chk("wrap_start", w_addr, 16'hFFFF);
        w_ack   = 1'b1;
        w_rdata = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w_ack = 1'b0;
            w_run = 1'b0;
            #1;
            chk("nop_no_wb", {w_wb_en, w_ill}, 2'b00);
        end
        @(negedge clk);
        w_run = 1'b1;
        #1;
        chk("wrap_cnt", w_cnt, 16'd1);
        chk("wrap_req", w_req, 1'b1);
        chk("wrap_pc", w_addr, 16'h0000);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback controller for the 16-bit CPU.
- Fetches instruction words from program memory over a req/ack handshake.
- Drives the instruction word, the register-file read addresses and the immediate N to the ALU.
- Captures the ALU result and writes it back to register Rd.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DATA_W, 16, instruction, data and address width (only 16 is supported).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  when 1, FETCH may issue requests; when 0, the sequencer pauses in FETCH
- mem_req  out  1  instruction fetch request
- mem_addr  out  16  fetch address (PC)
- mem_ack  in  1  fetch data valid this cycle
- mem_rdata  in  16  instruction word
- instruction  out  16  latched instruction register (IR), to the ALU
- N  out  16  immediate, sign-extended IR[4:0]
- rs_addr  out  3  register-file read address, IR[7:5]
- rm_addr  out  3  register-file read address, IR[4:2]
- aluout  in  16  ALU result (combinational from instruction and operands)
- wb_en  out  1  register write enable, one-cycle pulse
- wb_addr  out  3  write register, IR[10:8] (Rd)
- wb_data  out  16  write data
- illegal  out  1  one-cycle pulse when an unknown opcode retires
- halted  out  1  high in the HALT state
- instr_count  out  16  count of retired instructions

Behaviour:
- Field layout: opcode IR[15:12]; type IR[11] (0 = R, 1 = I); Rd IR[10:8]; Rs IR[7:5]; Rm IR[4:2].
- Immediate: N = {{11{IR[4]}}, IR[4:0]}, driven for every instruction.
- Opcodes:
  - 4'h0 NOP: no writeback.
  - 4'h8 ADD: writeback.
  - 4'h9 ADDI: writeback.
  - 4'hF HALT.
  - All others are illegal: no writeback, illegal pulses.
- Reset (rst_n = 0 at a clock edge):
  - state = FETCH, PC = RESET_PC, IR = 0, result register = 0, instr_count = 0.
  - mem_req, wb_en, illegal and halted are 0 while rst_n is low.
  - Reset mid-instruction discards the instruction; no partial writeback occurs.
- FETCH:
  - mem_req = run; mem_addr = PC.
  - Once asserted, mem_req and mem_addr stay stable until mem_ack.
  - On mem_req && mem_ack at an edge: IR <= mem_rdata, go to DECODE. mem_ack in the same cycle as req is legal.
  - mem_ack without mem_req is ignored.
  - If run drops while mem_req is high, the request stays asserted until acked.
- DECODE:
  - rs_addr/rm_addr are stable from IR. One cycle is allowed for the register-file read.
  - Always go to EXEC.
- EXEC: result <= aluout, go to WB.
- WB:
  - wb_en = 1 for exactly this cycle if the opcode writes; wb_data = result.
  - illegal = 1 this cycle for an unknown opcode.
  - PC <= PC + 1, wrapping 16'hFFFF to 16'h0000.
  - instr_count <= instr_count + 1, wrapping.
  - Next state is HALT if the opcode is HALT, else FETCH.
- HALT:
  - halted = 1, mem_req = 0. Exit only by reset.
  - HALT is counted as retired; PC advances past it.
- Minimum latency: 4 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC, WB).
  - Each wait cycle in FETCH adds 1.
- Output timing:
  - instruction, rs_addr, rm_addr, wb_addr and N are held from IR throughout DECODE..WB.
  - wb_en, illegal and mem_req are decoded from registered state; no combinational path from mem_ack to mem_req.
- Writing Rd = 0 is an ordinary write; there is no hard-wired zero register.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants OP_NOP, OP_ADD, OP_ADDI, OP_HALT;
  - field bit positions;
  - state enum FETCH/DECODE/EXEC/WB/HALT;
  - writes_rd(opcode) and is_legal(opcode) helper functions.
- One combinational sub-module, instr_fields, splits IR into opcode, type, Rd, Rs, Rm and N. It is shared with the future hazard logic.

Test Plan:
- Reset then run = 1, memory acks same cycle with 16'h8A48 (ADD Rd=2, Rs=2, Rm=2), aluout = 16'h0010 -> mem_addr 0, wb_en in cycle 4 with wb_addr = 2, wb_data = 16'h0010; PC = 1; instr_count = 1.
- Fetch 16'h991F (ADDI Rd=1, Rs=0, imm = -1) -> N = 16'hFFFF; wb_addr = 1; one wb_en pulse.
- mem_ack delayed 3 cycles -> mem_req and mem_addr held stable for those cycles; wb_en 3 cycles later than the no-wait case.
- Fetch 16'h5000 -> illegal pulses 1 cycle, wb_en stays 0, PC advances; then 16'hF000 -> halted = 1, mem_req stays 0 for 20 cycles.
- PC preset to 16'hFFFF via RESET_PC, execute NOP -> next mem_addr = 16'h0000.
- Assert rst_n = 0 during EXEC of an ADD -> no wb_en; on release, mem_addr = RESET_PC and instr_count = 0.
